melody_sequencer: RTL and testbench

//  Plays a stored melody on the note-frequency mux: steps through a small note/duration table and drives
//  the mux note-select code, holding each note for its programmed number of tempo ticks.

---
 rtl/melody_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a small note/duration table on the note-mux select code.
// Each non-zero-duration entry is held for dur tempo ticks, followed by GAP_TICKS silent ticks.
// Code 7 on note_select means silence.
// Optional build macro: MELODY_SEQUENCER_LOOP_EN (replay from entry 0 instead of finishing).
// Ports:
//   clk, rst (async, active-low)
//   start/stop     : playback control pulses, stop has priority
//   len            : number of valid entries, latched on accepted start (clamped to DEPTH)
//   wr_en/wr_addr/wr_note/wr_dur : table write port, usable at any time
//   note_select    : registered mux code, 7 when silent
//   busy/done      : playback active / one-cycle end-of-melody pulse
//   cur_idx        : index of the entry being played
module melody_sequencer #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DUR_W     = 8,
    parameter int unsigned GAP_TICKS = 20,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [AW:0]      len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [2:0]       wr_note,
    input  logic [DUR_W-1:0] wr_dur,
    output logic [3:0]       note_select,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    cur_idx
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned GW  = $clog2(GAP_TICKS + 1);
    localparam int unsigned TW  = (DUR_W > GW) ? DUR_W : GW;

`ifdef MELODY_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_NOTE = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Melody table: not reset, written from the board side at any time.
    logic [2:0]       note_mem [DEPTH];
    logic [DUR_W-1:0] dur_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    state_e           state_q, state_d;
    logic [AW:0]      idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [3:0]       note_select_q, note_select_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       rd_note;
    logic [DUR_W-1:0] rd_dur;
    logic             tick_end;
    logic [AW:0]      idx_inc;
    logic [AW:0]      adv_idx;
    state_e           adv_state;

    assign rd_note = note_mem[idx_q[AW-1:0]];
    assign rd_dur  = dur_mem[idx_q[AW-1:0]];

    // Next-state, counters and registered-output values
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        dur_d         = dur_q;
        presc_d       = presc_q;
        tick_d        = tick_q;
        note_select_d = note_select_q;

        tick_end = (presc_q == PW'(DIV - 1));
        idx_inc  = idx_q + (AW + 1)'(1);

        // Step to the following entry: next LOAD, or end / wrap after the last one
        adv_idx   = idx_inc;
        adv_state = S_LOAD;
        if (idx_inc >= len_q) begin
            if (LOOP) adv_idx   = '0;
            else      adv_state = S_DONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    len_d   = (len > (AW + 1)'(DEPTH)) ? (AW + 1)'(DEPTH) : len;
                end
            end
            S_LOAD: begin
                // Only reachable with idx >= len when the latched length is zero
                if (idx_q >= len_q) begin
                    state_d = S_DONE;
                end else if (rd_dur == '0) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else begin
                    state_d       = S_NOTE;
                    dur_d         = rd_dur;
                    note_select_d = {1'b0, rd_note};
                    presc_d       = '0;
                    tick_d        = '0;
                end
            end
            S_NOTE: begin
                presc_d = tick_end ? '0 : presc_q + PW'(1);
                if (tick_end) begin
                    tick_d = tick_q + TW'(1);
                    if ((tick_q + TW'(1)) == TW'(dur_q)) begin
                        tick_d = '0;
                        if (GAP_TICKS == 0) begin
                            state_d = adv_state;
                            idx_d   = adv_idx;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                presc_d = tick_end ? '0 : presc_q + PW'(1);
                if (tick_end) begin
                    tick_d = tick_q + TW'(1);
                    if ((tick_q + TW'(1)) == TW'(GAP_TICKS)) begin
                        tick_d  = '0;
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a simultaneous start
        if (stop) begin
            state_d = S_IDLE;
            presc_d = '0;
            tick_d  = '0;
        end

        if (state_d != S_NOTE) note_select_d = 4'd7;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            dur_q         <= '0;
            presc_q       <= '0;
            tick_q        <= '0;
            note_select_q <= 4'd7;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            dur_q         <= dur_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            note_select_q <= note_select_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign note_select = note_select_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cur_idx     = idx_q[AW-1:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: a per-cycle scoreboard fed by a reference model built from
// the melody rules (LOAD cycle, dur*DIV note cycles, GAP*DIV silent cycles, DONE pulse).
module tb_melody_sequencer;

    localparam int CLK_HZ = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int DUR_W = 8;
    localparam int GAP = 2;

`ifdef MELODY_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
    localparam int PASSES = 3;
`else
    localparam bit LOOP = 1'b0;
    localparam int PASSES = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [AW:0]      len = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [2:0]       wr_note = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic [3:0]       note_select;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_idx;

    melody_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
        .note_select(note_select), .busy(busy), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] note;
        logic       busy;
        logic       done;
        int         idx;   // -1: do not check
    } exp_t;

    exp_t sb_q[$];
    int   tbl_note [DEPTH];
    int   tbl_dur  [DEPTH];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected output triple per cycle; empty queue means idle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else e = '{note: 4'd7, busy: 1'b0, done: 1'b0, idx: -1};
            chk("note_select", 32'(note_select), 32'(e.note));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            if (e.idx >= 0) chk("cur_idx", 32'(cur_idx), 32'(e.idx));
        end
    end

    task automatic push(input int note, input bit b, input bit d, input int idx);
        exp_t e;
        e.note = 4'(note);
        e.busy = b;
        e.done = d;
        e.idx  = idx;
        sb_q.push_back(e);
    endtask

    // Reference model: the full cycle-by-cycle output of one accepted start
    task automatic push_run(input int len_in);
        int l;
        l = (len_in > DEPTH) ? DEPTH : len_in;
        if (l == 0) begin
            push(7, 1, 0, 0);
            push(7, 1, 1, -1);
            return;
        end
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < l; i++) begin
                push(7, 1, 0, i);
                if (tbl_dur[i] > 0) begin
                    for (int c = 0; c < tbl_dur[i] * DIV; c++) push(tbl_note[i], 1, 0, i);
                    for (int c = 0; c < GAP * DIV; c++) push(7, 1, 0, i);
                end
            end
        end
        if (LOOP) push(7, 1, 0, 0);
        else      push(7, 1, 1, -1);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int n, input int d);
        step();
        wr_en = 1'b1; wr_addr = AW'(a); wr_note = 3'(n); wr_dur = DUR_W'(d);
        tbl_note[a] = n;
        tbl_dur[a]  = d;
        step();
        wr_en = 1'b0;
    endtask

    // mode 0: play out; 1: stop after k cycles; 2: stray start pulses while busy; 3: reset after k
    task automatic play(input int l, input int mode, input int k);
        int n;
        step();
        start = 1'b1; len = (AW + 1)'(l);
        push_run(l);
        step();
        start = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 3000) begin
            if (mode == 1 && n == k) begin
                stop = 1'b1;
                sb_q.delete();
            end else if (mode == 2 && (n % 7) == 3) begin
                start = 1'b1;
            end else if (mode == 3 && n == k) begin
                rst = 1'b0;
                sb_q.delete();
                step();
                step();
                rst = 1'b1;
            end
            step();
            stop = 1'b0;
            start = 1'b0;
            n++;
        end
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL play_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        if (LOOP) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 mon_en = 1'b1;
        // Reset held for several cycles, then released: idle outputs throughout
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // Two-entry melody: A for 3 ticks, E for 1 tick
        wr(0, 0, 3);
        wr(1, 4, 1);
        play(2, 0, 0);

        // Zero-duration entry in the middle is skipped
        wr(0, 1, 2);
        wr(1, 5, 0);
        wr(2, 6, 1);
        play(3, 0, 0);

        // Stop mid-note, then a clean restart from entry 0
        play(3, 1, 15);
        play(3, 0, 0);

        // Zero length: LOAD then DONE, never a sounding note
        play(0, 0, 0);

        // Start and stop together: stays idle
        step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        repeat (3) step();

        // Length above DEPTH clamps, rest entry gives code 7
        wr(3, 7, 1);
        play(7, 0, 0);

        // Start pulses while busy are ignored; reset mid-playback silences at once
        play(4, 2, 0);
        play(4, 3, 40);

        for (int r = 0; r < 24; r++) begin
            for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            play(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(1, 80)));
        end

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
